// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, flush encoding and redirect FSM states shared by the IF/ID boundary
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {IDLE, PENDING} fsm_t;

    // Opcodes whose rt field is read as a source operand
    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_BEQ || op == OP_BNE ||
               op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the instruction in ID and a load in EX
module hazard_detect
    import mips_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        valid,
    input  logic        mem_read,
    input  logic [4:0]  ex_rt,
    output logic        hazard
);
    logic [4:0] rs;
    logic [4:0] rt;

    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    // $zero never carries a dependency, so a load to it cannot stall
    assign hazard = valid && mem_read && ex_rt != 5'd0 &&
                    (ex_rt == rs || (uses_rt(instruction[31:26]) && ex_rt == rt));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID register with load-use stall, branch flush and stalled-redirect replay
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_IF_data_PCNext,
    input  logic [31:0]      i_IF_data_instruction,
    input  logic             i_EX_ctrl_PCSrc,
    input  logic [31:0]      i_EX_data_PCBranch,
    input  logic             i_EX_ctrl_MemRead,
    input  logic [4:0]       i_EX_data_Rt,
    input  logic             i_ext_stall,
    output logic [31:0]      o_ID_data_instruction,
    output logic [31:0]      o_ID_data_PCNext,
    output logic             o_ID_ctrl_valid,
    output logic             o_EX_ctrl_bubble,
    output logic             o_IF_ctrl_stall,
    output logic             o_IF_ctrl_PCSrc,
    output logic [31:0]      o_IF_data_PCBranch,
    output logic [CNT_W-1:0] o_perf_stall_cnt,
    output logic [CNT_W-1:0] o_perf_flush_cnt
);
    import mips_pkg::*;

    fsm_t        state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        hazard;
    logic        redirect;
    logic        pending;

    hazard_detect u_hazard (
        .instruction(o_ID_data_instruction),
        .valid      (o_ID_ctrl_valid),
        .mem_read   (i_EX_ctrl_MemRead),
        .ex_rt      (i_EX_data_Rt),
        .hazard     (hazard)
    );

    assign pending            = state_q == PENDING;
    assign redirect           = i_EX_ctrl_PCSrc || pending;
    assign o_IF_ctrl_PCSrc    = i_EX_ctrl_PCSrc || (pending && !i_ext_stall);
    assign o_IF_data_PCBranch = i_EX_ctrl_PCSrc ? i_EX_data_PCBranch : target_q;
    assign o_IF_ctrl_stall    = i_ext_stall || (hazard && !redirect);
    assign o_EX_ctrl_bubble   = hazard && !redirect && !i_ext_stall;

    // Redirect FSM state and latched target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // A redirect seen while fetch is stalled is parked until the stall drops; the youngest target wins
    always_comb begin
        state_d  = (redirect && i_ext_stall) ? PENDING : IDLE;
        target_d = (i_EX_ctrl_PCSrc && i_ext_stall) ? i_EX_data_PCBranch : target_q;
    end

    // IF/ID register: flush beats hold beats capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ID_data_instruction <= NOP_INSTR;
            o_ID_data_PCNext      <= 32'd0;
            o_ID_ctrl_valid       <= 1'b0;
        end else if (redirect) begin
            o_ID_data_instruction <= NOP_INSTR;
            o_ID_ctrl_valid       <= 1'b0;
        end else if (!(i_ext_stall || hazard)) begin
            o_ID_data_instruction <= i_IF_data_instruction;
            o_ID_data_PCNext      <= i_IF_data_PCNext;
            o_ID_ctrl_valid       <= 1'b1;
        end
    end

    // Saturating counters; a branch counts once, on its live phase out of IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_stall_cnt <= '0;
            o_perf_flush_cnt <= '0;
        end else begin
            if (o_IF_ctrl_stall && o_perf_stall_cnt != '1) o_perf_stall_cnt <= o_perf_stall_cnt + 1'b1;
            if (i_EX_ctrl_PCSrc && !pending && o_perf_flush_cnt != '1) o_perf_flush_cnt <= o_perf_flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized and directed check of if_id_stage against a behavioural model
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0, if_instr = '0, ex_br = '0;
    logic        ex_pcsrc = 1'b0, ex_mr = 1'b0, ext = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic [31:0] id_instr, id_pc, if_tgt;
    logic        id_valid, bubble, stall, if_pcsrc;
    logic [15:0] scnt, fcnt;

    int total = 0, bad = 0;
    bit chk_en = 0;

    logic [31:0] m_instr, m_pc, m_tgt;
    logic        m_valid, m_pend;
    int          m_scnt, m_fcnt;

    if_id_stage #(.NOP_INSTR(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_IF_data_PCNext(if_pc), .i_IF_data_instruction(if_instr),
        .i_EX_ctrl_PCSrc(ex_pcsrc), .i_EX_data_PCBranch(ex_br),
        .i_EX_ctrl_MemRead(ex_mr), .i_EX_data_Rt(ex_rt), .i_ext_stall(ext),
        .o_ID_data_instruction(id_instr), .o_ID_data_PCNext(id_pc),
        .o_ID_ctrl_valid(id_valid), .o_EX_ctrl_bubble(bubble),
        .o_IF_ctrl_stall(stall), .o_IF_ctrl_PCSrc(if_pcsrc),
        .o_IF_data_PCBranch(if_tgt),
        .o_perf_stall_cnt(scnt), .o_perf_flush_cnt(fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_hazard();
        logic [5:0] op;
        bit src_rt;
        op = m_instr[31:26];
        src_rt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        return m_valid && ex_mr && ex_rt != 0 &&
               (ex_rt == m_instr[25:21] || (src_rt && ex_rt == m_instr[20:16]));
    endfunction

    function automatic bit m_stall();
        return ext || (m_hazard() && !(ex_pcsrc || m_pend));
    endfunction

    // Reference model: what the boundary must hold after each clock
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_instr <= 0; m_pc <= 0; m_valid <= 0; m_pend <= 0; m_tgt <= 0;
            m_scnt <= 0; m_fcnt <= 0;
        end else begin
            if (m_stall()) m_scnt <= (m_scnt == 65535) ? 65535 : m_scnt + 1;
            if (ex_pcsrc && !m_pend) m_fcnt <= (m_fcnt == 65535) ? 65535 : m_fcnt + 1;
            if (ex_pcsrc || m_pend) begin
                m_instr <= 0;
                m_valid <= 0;
            end else if (!(ext || m_hazard())) begin
                m_instr <= if_instr;
                m_pc <= if_pc;
                m_valid <= 1;
            end
            m_pend <= ext && (ex_pcsrc || m_pend);
            if (ex_pcsrc && ext) m_tgt <= ex_br;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr", id_instr, m_instr);
            chk("pcnext", id_pc, m_pc);
            chk("valid", 32'(id_valid), 32'(m_valid));
            chk("stall", 32'(stall), 32'(m_stall()));
            chk("bubble", 32'(bubble), 32'(m_hazard() && !(ex_pcsrc || m_pend) && !ext));
            chk("if_pcsrc", 32'(if_pcsrc), 32'(ex_pcsrc || (m_pend && !ext)));
            chk("if_target", if_tgt, ex_pcsrc ? ex_br : m_tgt);
            chk("stall_cnt", 32'(scnt), 32'(m_scnt));
            chk("flush_cnt", 32'(fcnt), 32'(m_fcnt));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [7];
        logic [31:0] w;
        ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h28};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 6)];
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1;
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_scnt", 32'(scnt), 32'h0);
        chk("rst_fcnt", 32'(fcnt), 32'h0);

        if_pc = 32'd4; if_instr = 32'h20080005; tick();
        chk("stream0_instr", id_instr, 32'h20080005);
        chk("stream0_pc", id_pc, 32'd4);
        chk("stream0_valid", 32'(id_valid), 32'h1);
        chk("stream0_stall", 32'(stall), 32'h0);
        if_pc = 32'd8; if_instr = 32'h20090003; tick();
        chk("stream1_instr", id_instr, 32'h20090003);
        chk("stream1_pc", id_pc, 32'd8);

        if_pc = 32'd12; if_instr = 32'h01095020; tick();
        ex_mr = 1; ex_rt = 5'd8; if_pc = 32'd16; if_instr = 32'h0; #1;
        chk("lu_stall", 32'(stall), 32'h1);
        chk("lu_bubble", 32'(bubble), 32'h1);
        tick();
        chk("lu_hold_instr", id_instr, 32'h01095020);
        chk("lu_hold_pc", id_pc, 32'd12);
        chk("lu_scnt", 32'(scnt), 32'h1);
        ex_mr = 0; #1;
        chk("lu_release", 32'(stall), 32'h0);
        tick();

        if_pc = 32'd20; if_instr = 32'h01095020; tick();
        ex_mr = 1; ex_rt = 5'd0; #1;
        chk("rt0_nostall", 32'(stall), 32'h0);
        ex_mr = 0;
        if_pc = 32'd24; if_instr = 32'h20080005; tick();
        ex_mr = 1; ex_rt = 5'd8; #1;
        chk("addi_nostall", 32'(stall), 32'h0);
        ex_mr = 0;

        ex_pcsrc = 1; ex_br = 32'h40; #1;
        chk("br_pcsrc", 32'(if_pcsrc), 32'h1);
        chk("br_target", if_tgt, 32'h40);
        tick();
        ex_pcsrc = 0;
        chk("br_flush_instr", id_instr, 32'h0);
        chk("br_flush_valid", 32'(id_valid), 32'h0);
        chk("br_fcnt", 32'(fcnt), 32'h1);

        ex_pcsrc = 1; ex_br = 32'h80; ext = 1; tick();
        ex_pcsrc = 0; ex_br = 32'h0; #1;
        chk("pend_pcsrc_low", 32'(if_pcsrc), 32'h0);
        chk("pend_target", if_tgt, 32'h80);
        tick();
        tick();
        ext = 0; #1;
        chk("replay_pcsrc", 32'(if_pcsrc), 32'h1);
        chk("replay_target", if_tgt, 32'h80);
        tick();
        chk("replay_once", 32'(if_pcsrc), 32'h0);
        chk("replay_fcnt", 32'(fcnt), 32'h2);
        chk("replay_scnt", 32'(scnt), 32'h4);

        if_pc = 32'd28; if_instr = 32'h01095020; tick();
        ex_mr = 1; ex_rt = 5'd8; ex_pcsrc = 1; ex_br = 32'h100; #1;
        chk("flushwin_stall", 32'(stall), 32'h0);
        chk("flushwin_bubble", 32'(bubble), 32'h0);
        chk("flushwin_pcsrc", 32'(if_pcsrc), 32'h1);
        tick();
        ex_pcsrc = 0; ex_mr = 0;
        chk("flushwin_fcnt", 32'(fcnt), 32'h3);

        ex_pcsrc = 1; ex_br = 32'h200; ext = 1; tick();
        ex_pcsrc = 0; rst = 1; #1;
        chk("rstpend_valid", 32'(id_valid), 32'h0);
        chk("rstpend_fcnt", 32'(fcnt), 32'h0);
        chk("rstpend_scnt", 32'(scnt), 32'h0);
        tick();
        rst = 0; ext = 0; #1;
        chk("rstpend_noreplay", 32'(if_pcsrc), 32'h0);
        chk("rstpend_target", if_tgt, 32'h0);
        tick();

        ext = 1;
        repeat (65541) tick();
        chk("sat_scnt", 32'(scnt), 32'hFFFF);
        ext = 0;

        repeat (3000) begin
            if_pc = $urandom;
            if_instr = rand_instr();
            ext = ($urandom_range(0, 4) == 0);
            ex_pcsrc = ($urandom_range(0, 7) == 0);
            ex_br = $urandom;
            ex_mr = ($urandom_range(0, 2) == 0);
            ex_rt = 5'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline boundary directly downstream of the fetch stage. Registers the fetched instruction and PC+4 for decode.
- Detects load-use hazards against the EX stage and drives the fetch stall.
- Flushes on branch redirect.
- Latches a redirect that arrives during an external stall and replays it to fetch once the stall drops, so no redirect is lost.

Parameters:
- NOP_INSTR, 32'h00000000, encoding injected on flush.
- CNT_W, 16, width of saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_IF_data_PCNext  in  32  PC+4 from fetch
- i_IF_data_instruction  in  32  fetched instruction
- i_EX_ctrl_PCSrc  in  1  branch/jump taken, resolved in EX
- i_EX_data_PCBranch  in  32  redirect target
- i_EX_ctrl_MemRead  in  1  EX-stage instruction is a load
- i_EX_data_Rt  in  5  load destination register
- i_ext_stall  in  1  external (memory) stall request
- o_ID_data_instruction  out  32  registered instruction
- o_ID_data_PCNext  out  32  registered PC+4
- o_ID_ctrl_valid  out  1  register holds a live instruction
- o_EX_ctrl_bubble  out  1  ID/EX must load a NOP this cycle
- o_IF_ctrl_stall  out  1  fetch hold
- o_IF_ctrl_PCSrc  out  1  redirect to fetch (live or replayed)
- o_IF_data_PCBranch  out  32  redirect target to fetch
- o_perf_stall_cnt  out  CNT_W  cycles with o_IF_ctrl_stall=1, saturating
- o_perf_flush_cnt  out  CNT_W  flushes performed, saturating

Behaviour:
- Reset (async, rst=1): instruction=NOP_INSTR, PCNext=0, valid=0, FSM=IDLE, pending target=0, both counters=0.
- rs=instr[25:21], rt=instr[20:16], op=instr[31:26].
- uses_rt is true for op 6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B.
- hazard = valid & i_EX_ctrl_MemRead & (i_EX_data_Rt!=0) & ((i_EX_data_Rt==rs) | (uses_rt & i_EX_data_Rt==rt)). Combinational.
- redirect = i_EX_ctrl_PCSrc | (FSM==PENDING).
- FSM IDLE:
  - i_EX_ctrl_PCSrc & i_ext_stall -> PENDING; latch i_EX_data_PCBranch; register flushed.
  - Otherwise stay IDLE.
- FSM PENDING:
  - Hold the latched target while i_ext_stall=1.
  - When i_ext_stall=0: assert o_IF_ctrl_PCSrc for exactly that cycle with the latched target, then -> IDLE.
  - A new i_EX_ctrl_PCSrc while PENDING overwrites the latched target (youngest redirect wins).
- o_IF_ctrl_PCSrc = i_EX_ctrl_PCSrc | (PENDING & ~i_ext_stall).
- o_IF_data_PCBranch = live target when i_EX_ctrl_PCSrc=1, else latched target.
- o_IF_ctrl_stall = i_ext_stall | (hazard & ~redirect). Flush overrides hazard; a pending redirect is never masked by a hazard stall.
- o_EX_ctrl_bubble = hazard & ~redirect & ~i_ext_stall.
- Register update priority at each posedge (highest first):
  1. Redirect: load NOP_INSTR, valid=0, PCNext unchanged. Count one flush per redirect event; the live and replay phases of a single branch count once.
  2. i_ext_stall or hazard: hold all fields.
  3. Else: capture IF inputs, valid=1.
- Latency: IF inputs appear on outputs 1 cycle after capture. Load-use costs exactly 1 stall cycle when the EX load advances normally.
- Counters saturate at all-ones with no wrap.
- Reset mid-PENDING discards the latched redirect.

Decomposition:
- Shared package mips_pkg: opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW; NOP_INSTR; fsm enum {IDLE, PENDING}.
- One sub-module, hazard_detect: the combinational hazard/uses_rt logic, so the ID/EX stage can reuse it.

Test Plan:
- Reset then stream 0x20080005, 0x20090003 at PCNext 4, 8 -> outputs show those values 1 cycle later; valid=1; stall=0.
- EX lw with Rt=8, ID add $10,$8,$9 (0x01095020) -> stall=1 and bubble=1 for one cycle; register held; stall counter=1.
- Same but Rt=0 -> no stall.
- ID addi rt=8 with EX Rt=8 -> no stall (rt not used as a source).
- i_EX_ctrl_PCSrc=1, target 0x40 with no stall -> o_IF_ctrl_PCSrc=1 with 0x40 the same cycle; next cycle instruction=NOP, valid=0; flush counter=1.
- PCSrc=1 target 0x80 while i_ext_stall=1 for 3 cycles -> FSM PENDING and o_IF_ctrl_PCSrc low while stalled; on the first unstalled cycle o_IF_ctrl_PCSrc=1 with 0x80 for one cycle; FSM returns to IDLE.
- Hazard concurrent with PCSrc -> no stall; flush wins.
- Assert rst during PENDING -> all outputs back to reset values and no replay occurs.
- Force 2^16+5 stall cycles -> o_perf_stall_cnt=16'hFFFF.
